// File: rtl/riscv_pkg.sv
// Shared core-wide types and constants used by the fetch-side predictors.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_WEAK_T = 2'b10;
  localparam ctr_t CTR_INIT   = 2'b01;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating up/down direction counter.
module sat_counter2 (
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, resolve-time update.
module branch_target_buffer #(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter int unsigned ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_mispred_i,
  input  logic            inval_i,
  output logic [31:0]     perf_hits_o,
  output logic [31:0]     perf_mispred_o
);
  import riscv_pkg::*;

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 1;

  // Target bit 0 is always zero for 2-byte aligned PCs, so it is not stored.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-2:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_entry;

  assign lk_idx   = lookup_pc_i[IDX_W:1];
  assign lk_tag   = lookup_pc_i[XLEN-1:IDX_W+1];
  assign lk_entry = btb_q[lk_idx];

  always_comb begin
    hit_o    = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
    target_o = hit_o ? {lk_entry.target, 1'b0} : '0;
  end

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       upd_cur;
  btb_entry_t       upd_entry;
  logic             upd_match;
  logic             upd_we;
  ctr_t             ctr_next;

  assign upd_idx   = upd_pc_i[IDX_W:1];
  assign upd_tag   = upd_pc_i[XLEN-1:IDX_W+1];
  assign upd_cur   = btb_q[upd_idx];
  assign upd_match = upd_cur.valid && (upd_cur.tag == upd_tag);

  sat_counter2 u_ctr (
    .ctr_i (upd_cur.ctr),
    .inc_i (upd_taken_i),
    .ctr_o (ctr_next)
  );

  always_comb begin
    upd_entry = upd_cur;
    upd_we    = 1'b0;
    if (upd_en_i) begin
      if (upd_match) begin
        upd_we        = 1'b1;
        upd_entry.ctr = ctr_next;
        if (upd_taken_i) upd_entry.target = upd_target_i[XLEN-1:1];
      end else if (upd_taken_i) begin
        upd_we           = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = upd_tag;
        upd_entry.target = upd_target_i[XLEN-1:1];
        upd_entry.ctr    = CTR_WEAK_T;
      end
    end
  end

  // Invalidate wins over a same-cycle update; counters survive fence.i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= CTR_INIT;
      end
    end else if (inval_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i].valid <= 1'b0;
      end
    end else if (upd_we) begin
      btb_q[upd_idx] <= upd_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_hits_o    <= '0;
      perf_mispred_o <= '0;
    end else begin
      if (hit_o) perf_hits_o <= perf_hits_o + 32'd1;
      if (upd_en_i && upd_mispred_i) perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc_i[0], upd_pc_i[0], upd_target_i[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: vector table plus hand-written corner sequences.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] lookup_pc;
  logic        hit_o;
  logic [31:0] target_o;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        inval;
  logic [31:0] perf_hits;
  logic [31:0] perf_mispred;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .lookup_pc_i    (lookup_pc),
    .hit_o          (hit_o),
    .target_o       (target_o),
    .upd_en_i       (upd_en),
    .upd_pc_i       (upd_pc),
    .upd_taken_i    (upd_taken),
    .upd_target_i   (upd_target),
    .upd_mispred_i  (upd_mispred),
    .inval_i        (inval),
    .perf_hits_o    (perf_hits),
    .perf_mispred_o (perf_mispred)
  );

  typedef struct {
    string       name;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        taken;
    logic [31:0] upd_tgt;
    logic [31:0] look_pc;
    logic        exp_hit;
    logic [31:0] exp_tgt;
  } vec_t;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] tgt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input string nm, input logic en, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic [31:0] lp, input logic eh,
                     input logic [31:0] et);
    vec_t v;
    v.name = nm; v.upd_en = en; v.upd_pc = pc; v.taken = tk; v.upd_tgt = tg;
    v.look_pc = lp; v.exp_hit = eh; v.exp_tgt = et;
    vecs.push_back(v);
  endtask

  task automatic set_upd(input logic en, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic mp);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispred = mp;
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic [31:0] et,
                      input string nm);
    exp_t e;
    lookup_pc = pc;
    e.name = nm; e.hit = eh; e.tgt = et;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb.pop_front();
      if (hit_o !== e.hit || target_o !== e.tgt) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b target=%h, want hit=%0b target=%h",
                 e.name, hit_o, target_o, e.hit, e.tgt);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // One table row per clock: lookup sees pre-update state, update lands on the edge.
  task automatic run_row(input vec_t v);
    set_upd(v.upd_en, v.upd_pc, v.taken, v.upd_tgt, 1'b0);
    look(v.look_pc, v.exp_hit, v.exp_tgt, v.name);
    @(negedge clk);
    check_sb();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    inval = 1'b0;
    lookup_pc = 32'h8000_0000;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    add("r0_reset_miss",  0, 32'h0,         0, 32'h0,         32'h8000_0000, 0, 32'h0);
    add("r1_alloc_same",  1, 32'h8000_0010, 1, 32'h8000_0100, 32'h8000_0010, 0, 32'h0);
    add("r2_alloc_hit",   0, 32'h0,         0, 32'h0,         32'h8000_0010, 1, 32'h8000_0100);
    add("r3_neighbour",   0, 32'h0,         0, 32'h0,         32'h8000_0012, 0, 32'h0);
    add("r4_ctr10",       1, 32'h8000_0010, 0, 32'h0,         32'h8000_0010, 1, 32'h8000_0100);
    add("r5_ctr01",       1, 32'h8000_0010, 1, 32'h8000_0100, 32'h8000_0010, 0, 32'h0);
    add("r6_ctr10",       1, 32'h8000_0010, 1, 32'h8000_0100, 32'h8000_0010, 1, 32'h8000_0100);
    add("r7_ctr11",       1, 32'h8000_0010, 0, 32'h0,         32'h8000_0010, 1, 32'h8000_0100);
    add("r8_ctr10",       1, 32'h8000_0010, 0, 32'h0,         32'h8000_0010, 1, 32'h8000_0100);
    add("r9_ctr01",       1, 32'h8000_0010, 0, 32'h0,         32'h8000_0010, 0, 32'h0);
    add("r10_ctr00",      1, 32'h8000_0010, 0, 32'h0,         32'h8000_0010, 0, 32'h0);
    add("r11_ctr00_sat",  1, 32'h8000_0010, 1, 32'h8000_0104, 32'h8000_0010, 0, 32'h0);
    add("r12_ctr01",      1, 32'h8000_0010, 1, 32'h8000_0108, 32'h8000_0010, 0, 32'h0);
    add("r13_tgt_update", 0, 32'h0,         0, 32'h0,         32'h8000_0010, 1, 32'h8000_0108);
    add("r14_pre_alias",  1, 32'h8000_0090, 1, 32'h8000_0200, 32'h8000_0010, 1, 32'h8000_0108);
    add("r15_evicted",    0, 32'h0,         0, 32'h0,         32'h8000_0010, 0, 32'h0);
    add("r16_alias_hit",  1, 32'h8000_0010, 0, 32'h0,         32'h8000_0090, 1, 32'h8000_0200);
    add("r17_nt_no_evict",0, 32'h0,         0, 32'h0,         32'h8000_0090, 1, 32'h8000_0200);
    add("r18_same_cycle", 1, 32'h8000_0020, 1, 32'h8000_0300, 32'h8000_0020, 0, 32'h0);
    add("r19_next_cycle", 0, 32'h0,         0, 32'h0,         32'h8000_0020, 1, 32'h8000_0300);
    add("r20_odd_tgt",    1, 32'h8000_0020, 1, 32'h8000_0401, 32'h8000_0020, 1, 32'h8000_0300);
    add("r21_tgt_bit0",   0, 32'h0,         0, 32'h0,         32'h8000_0020, 1, 32'h8000_0400);

    repeat (2) @(posedge clk);
    @(negedge clk);
    look(32'h8000_0000, 1'b0, 32'h0, "in_reset");
    #1 check_sb();
    chk("reset_perf_hits", perf_hits, 32'd0);
    chk("reset_perf_mispred", perf_mispred, 32'd0);
    rstn = 1'b1;

    @(posedge clk);
    #1;
    foreach (vecs[i]) run_row(vecs[i]);

    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    lookup_pc = 32'h0;
    @(negedge clk);
    chk("perf_hits_table", perf_hits, 32'd12);
    chk("perf_mispred_zero", perf_mispred, 32'd0);

    // Three mispredicted not-taken updates to an empty slot.
    @(posedge clk);
    #1 set_upd(1'b1, 32'h8000_0080, 1'b0, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1 set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("perf_mispred_3", perf_mispred, 32'd3);
    chk("perf_hits_held", perf_hits, 32'd12);

    // Invalidate together with an allocating update.
    @(posedge clk);
    #1 inval = 1'b1;
    set_upd(1'b1, 32'h8000_0040, 1'b1, 32'h8000_0500, 1'b0);
    look(32'h8000_0090, 1'b1, 32'h8000_0200, "pre_inval");
    @(negedge clk) check_sb();
    @(posedge clk);
    #1 inval = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(32'h8000_0090, 1'b0, 32'h0, "inval_0090");
    @(negedge clk) check_sb();
    @(posedge clk);
    #1 look(32'h8000_0020, 1'b0, 32'h0, "inval_0020");
    @(negedge clk) check_sb();
    @(posedge clk);
    #1 look(32'h8000_0040, 1'b0, 32'h0, "inval_upd_dropped");
    @(negedge clk) check_sb();

    // Reallocate, then idle with undriven update fields.
    @(posedge clk);
    #1 set_upd(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0600, 1'b0);
    look(32'h8000_0020, 1'b0, 32'h0, "realloc_same");
    @(negedge clk) check_sb();
    @(posedge clk);
    #1 upd_en = 1'b0;
    upd_pc = 'x; upd_taken = 1'bx; upd_target = 'x; upd_mispred = 1'bx;
    look(32'h8000_0020, 1'b1, 32'h8000_0600, "realloc_hit");
    @(negedge clk) check_sb();
    @(posedge clk);
    #1 look(32'h8000_0020, 1'b1, 32'h8000_0600, "x_safe");
    @(negedge clk) check_sb();

    // Asynchronous reset mid-cycle, with an update pending across a reset edge.
    #2 rstn = 1'b0;
    set_upd(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0700, 1'b0);
    look(32'h8000_0020, 1'b0, 32'h0, "async_reset_drop");
    #1 check_sb();
    chk("async_perf_hits", perf_hits, 32'd0);
    chk("async_perf_mispred", perf_mispred, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1 look(32'h8000_0020, 1'b0, 32'h0, "reset_discards_upd");
    @(negedge clk) check_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch presents its current PC; the BTB answers the same cycle with a predicted-taken flag and target.
- Execute/resolve writes back branch outcomes.
- Sits beside the fetch stage and supplies the fetch hit/target inputs. PCs are 2-byte aligned because compressed instructions are supported.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, number of entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width (derived, localparam).
- TAG_W, XLEN-IDX_W-1, tag width (derived, localparam).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- lookup_pc_i  in  XLEN  fetch PC (pc_q of fetch)
- hit_o  out  1  predict taken: entry valid, tag match, ctr[1]=1
- target_o  out  XLEN  predicted target; valid only when hit_o=1
- upd_en_i  in  1  resolved control-transfer update, one per cycle
- upd_pc_i  in  XLEN  PC of resolved branch/jump
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  XLEN  actual target (ignored when not taken)
- upd_mispred_i  in  1  resolve stage detected misprediction (informational, perf only)
- inval_i  in  1  invalidate all entries (fence.i)
- perf_hits_o  out  32  count of lookups with hit_o=1 while lookup_pc_i changed or was re-presented
- perf_mispred_o  out  32  count of upd_en_i & upd_mispred_i

Behaviour:
- Index = pc[IDX_W:1]; tag = pc[XLEN-1:IDX_W+1]. Bit 0 is never used.
- Per entry: valid (1b), tag (TAG_W), target (XLEN-1 bits, target[0] stored as 0), ctr (2b).
- Lookup is purely combinational from lookup_pc_i and the state register array; there is no read latency.
- Reset (async, rstn_i=0):
  - all valid=0, all ctr=2'b01.
  - Perf counters cleared to 0.
  - hit_o=0, target_o=0 immediately.
  - Reset mid-update discards the update.
- Update on rising edge when upd_en_i=1, comparing tag at index(upd_pc_i):
  - Tag match and valid: ctr saturating +1 if taken (max 2'b11), -1 if not taken (min 2'b00). If taken, target is overwritten with upd_target_i.
  - Miss and taken: allocate (replace any occupant). valid=1, tag written, target=upd_target_i, ctr=2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The new state is visible the next cycle; there is no bypass.
- inval_i: all valid cleared at the next edge and takes priority over a same-cycle upd_en_i. Counters are not reset.
- perf_hits_o:
  - Increments by 1 on each clock edge where hit_o=1.
  - Fetch stalls hold the PC, so repeated hits count repeatedly; this is accepted as a stall-biased metric.
  - Wraps modulo 2^32.
- perf_mispred_o: increments on upd_en_i & upd_mispred_i; wraps modulo 2^32.
- X-safety: with upd_en_i=0, the upd_* inputs may be X without corrupting state.

Decomposition:
- riscv_pkg gets XLEN (already present) and a btb_entry_t packed struct (valid, tag, target, ctr), parameterised via a localparam TAG_W computed in the module.
- Add to the package: a ctr_t 2-bit typedef, constants CTR_WEAK_T=2'b10 and CTR_INIT=2'b01.
- One natural sub-module: sat_counter2, a combinational next-state function for the 2-bit counter (inc/dec with saturation), reused later by a gshare predictor.

Test Plan:
- Reset, then lookup 0x8000_0000 -> hit_o=0, perf counters 0.
- Allocate and hit:
  - Update pc=0x8000_0010, taken, target=0x8000_0100.
  - Next cycle lookup 0x8000_0010 -> hit_o=1, target_o=0x8000_0100.
  - Lookup 0x8000_0012 -> hit_o=0.
- Hysteresis: from the allocated entry (ctr=10), one not-taken update -> ctr=01, hit_o=0. Two taken updates -> ctr=11, hit_o=1. Three not-taken -> ctr=00; a fourth not-taken stays 00.
- Alias (ENTRIES=64):
  - 0x8000_0010 taken, then 0x8000_0090 taken to 0x8000_0200.
  - Lookup 0x8000_0010 -> hit_o=0; lookup 0x8000_0090 -> target 0x8000_0200.
  - Not-taken update to an unallocated alias leaves the occupant intact.
- Same-cycle update/lookup on 0x8000_0020 first allocation -> hit_o=0 that cycle, 1 next cycle.
- Invalidate: inval_i together with upd_en_i -> all lookups miss afterwards. upd_en_i+upd_mispred_i for 3 cycles -> perf_mispred_o=3. Async rstn_i pulse mid-cycle -> hit_o drops without waiting for a clock edge.
